msgpass_rqst_stream_seq: RTL and testbench

//  Parametrised read sequencer streaming request patterns from the message-pass buffer into the memShare

---
 rtl/msgpass_rqst_stream_seq_pkg.sv | 34 +++
 rtl/msgpass_rqst_stream_seq_lane_unpack.sv | 31 +++
 rtl/msgpass_rqst_stream_seq.sv | 156 +++++++++++++++
 tb/tb_msgpass_rqst_stream_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msgpass_rqst_stream_seq_pkg.sv
// ----------------------------------------------------------------------------
// msgpass_rqst_stream_seq_pkg
//  Shared configuration for the message-pass request stream sequencer:
//  default sizing, the sequencer state encoding and the lane-field layout
//  helpers used when slicing a buffer entry into per-lane request fields.
//  Buffer entry layout: lane i occupies bits [i*LANE_W +: LANE_W]. The lane
//  MSB is the lane-valid flag and the remaining LSBs are the request address.
// ----------------------------------------------------------------------------
package msgpass_rqst_stream_seq_pkg;

  localparam int SHARE_GROUP_SIZE_DEF   = 5;
  localparam int RQST_ADDR_BITWIDTH_DEF = 3;
  localparam int BUFF_ADDR_WIDTH_DEF    = 4;
  localparam int DRC_NUM_DEF            = 1;
  localparam int STALL_CNT_W_DEF        = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  // Width of one lane field: address bits plus the lane-valid flag.
  function automatic int lane_width(input int addr_bits);
    return addr_bits + 1;
  endfunction

  // Bit position of the least significant bit of a lane field in an entry.
  function automatic int lane_lsb(input int lane, input int addr_bits);
    return lane * lane_width(addr_bits);
  endfunction

endpackage

// File: rtl/msgpass_rqst_stream_seq_lane_unpack.sv
// ----------------------------------------------------------------------------
// msgpass_lane_unpack
//  Combinational lane slicer. Splits a buffer entry into per-lane request
//  addresses and per-lane valid flags. Both outputs are forced to zero when
//  i_vld is low so downstream never sees stale buffer contents.
//  Ports:
//   i_vld       entry currently carries live data
//   i_rdata     raw buffer entry, SHARE_GROUP_SIZE lanes of LANE_W bits
//   o_rqst_addr lane addresses with the valid flags stripped
//   o_lane_vld  per-lane valid flags
// ----------------------------------------------------------------------------
module msgpass_lane_unpack
  import msgpass_rqst_stream_seq_pkg::*;
#(
  parameter int SHARE_GROUP_SIZE   = SHARE_GROUP_SIZE_DEF,
  parameter int RQST_ADDR_BITWIDTH = RQST_ADDR_BITWIDTH_DEF
) (
  input  logic                                           i_vld,
  input  logic [SHARE_GROUP_SIZE*(RQST_ADDR_BITWIDTH+1)-1:0] i_rdata,
  output logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0]     o_rqst_addr,
  output logic [SHARE_GROUP_SIZE-1:0]                        o_lane_vld
);

  for (genvar g = 0; g < SHARE_GROUP_SIZE; g++) begin : g_lane
    localparam int LSB = lane_lsb(g, RQST_ADDR_BITWIDTH);
    assign o_rqst_addr[g*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH] =
      i_vld ? i_rdata[LSB +: RQST_ADDR_BITWIDTH] : '0;
    assign o_lane_vld[g] = i_vld & i_rdata[LSB + RQST_ADDR_BITWIDTH];
  end

endmodule

// File: rtl/msgpass_rqst_stream_seq.sv
// ----------------------------------------------------------------------------
// msgpass_rqst_stream_seq
//  Read sequencer streaming request entries from the message-pass buffer
//  (read port A, one-cycle synchronous read) into the memShare controller.
//  Programmable base/length with address wrap, loop mode, DRC back-pressure
//  with entry replay, abort, and a saturating DRC stall counter.
//  Ports:
//   sys_clk, rst  clock, asynchronous active-high reset
//   start_i       start pulse, honoured only in IDLE
//   abort_i       return to IDLE next cycle from any state (beats start_i)
//   loop_en_i     restart at base after the last entry until aborted
//   base_addr_i   first entry address, latched on start
//   len_i         entry count (0 = no-op run), latched on start
//   is_drc_i      any bit high rejects the presented entry; it is replayed
//   raddr_o       buffer read address (combinational from is_drc_i)
//   rdata_i       buffer read data
//   rqst_addr_o   lane addresses, zero unless rqst_vld_o
//   lane_vld_o    lane valid flags, zero unless rqst_vld_o
//   rqst_vld_o    a live entry is presented
//   busy_o        sequencer not idle
//   done_o        one-cycle pulse after the last entry of a non-loop run
//   stall_cnt_o   saturating count of DRC-stalled cycles, cleared on start
// ----------------------------------------------------------------------------
module msgpass_rqst_stream_seq
  import msgpass_rqst_stream_seq_pkg::*;
#(
  parameter int SHARE_GROUP_SIZE   = SHARE_GROUP_SIZE_DEF,
  parameter int RQST_ADDR_BITWIDTH = RQST_ADDR_BITWIDTH_DEF,
  parameter int BUFF_ADDR_WIDTH    = BUFF_ADDR_WIDTH_DEF,
  parameter int DRC_NUM            = DRC_NUM_DEF,
  parameter int STALL_CNT_W        = STALL_CNT_W_DEF
) (
  input  logic                                              sys_clk,
  input  logic                                              rst,
  input  logic                                              start_i,
  input  logic                                              abort_i,
  input  logic                                              loop_en_i,
  input  logic [BUFF_ADDR_WIDTH-1:0]                        base_addr_i,
  input  logic [BUFF_ADDR_WIDTH:0]                          len_i,
  input  logic [DRC_NUM-1:0]                                is_drc_i,
  output logic [BUFF_ADDR_WIDTH-1:0]                        raddr_o,
  input  logic [SHARE_GROUP_SIZE*(RQST_ADDR_BITWIDTH+1)-1:0] rdata_i,
  output logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0]     rqst_addr_o,
  output logic [SHARE_GROUP_SIZE-1:0]                        lane_vld_o,
  output logic                                              rqst_vld_o,
  output logic                                              busy_o,
  output logic                                              done_o,
  output logic [STALL_CNT_W-1:0]                             stall_cnt_o
);

  localparam int LEN_W = BUFF_ADDR_WIDTH + 1;
  localparam logic [BUFF_ADDR_WIDTH-1:0] PTR_ONE   = {{(BUFF_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]           LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0]     STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  seq_state_e                 r_state;
  logic [BUFF_ADDR_WIDTH-1:0] r_ptr;
  logic [BUFF_ADDR_WIDTH-1:0] r_base;
  logic [LEN_W-1:0]           r_len;
  logic [LEN_W-1:0]           r_cnt;
  logic [STALL_CNT_W-1:0]     r_stall;

  logic                       w_vld;
  logic                       w_drc;
  logic                       w_consume;
  logic                       w_last;
  logic [BUFF_ADDR_WIDTH-1:0] w_raddr;

  assign w_vld     = (r_state == STREAM);
  assign w_drc     = |is_drc_i;
  assign w_consume = w_vld & ~w_drc;
  assign w_last    = w_consume & (r_cnt == (r_len - LEN_ONE));

  // Next read address. A rejected entry is simply re-read at ptr; the
  // natural overflow of ptr+1 gives the wrap from the top of the buffer.
  always_comb begin
    w_raddr = r_ptr;
    if (w_consume) begin
      if (w_last) begin
        w_raddr = loop_en_i ? r_base : r_ptr;
      end else begin
        w_raddr = r_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_stall <= '0;
    end else begin
      r_ptr <= w_raddr;
      case (r_state)
        IDLE: begin
          if (start_i && !abort_i) begin
            r_cnt   <= '0;
            r_stall <= '0;
            if (len_i == '0) begin
              // Empty run: report completion without touching the buffer.
              r_state <= DONE;
            end else begin
              r_ptr   <= base_addr_i;
              r_state <= PRIME;
            end
          end
        end
        PRIME: r_state <= STREAM;
        STREAM: begin
          if (w_drc && !(&r_stall)) begin
            r_stall <= r_stall + STALL_ONE;
          end
          if (w_last) begin
            r_cnt <= '0;
            if (!loop_en_i) begin
              r_state <= DONE;
            end
          end else if (w_consume) begin
            r_cnt <= r_cnt + LEN_ONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (abort_i) begin
        r_state <= IDLE;
      end
    end
  end

  // Run configuration is only meaningful while busy, so it carries no reset.
  always_ff @(posedge sys_clk) begin
    if (r_state == IDLE && start_i && !abort_i) begin
      r_base <= base_addr_i;
      r_len  <= len_i;
    end
  end

  msgpass_lane_unpack #(
    .SHARE_GROUP_SIZE   (SHARE_GROUP_SIZE),
    .RQST_ADDR_BITWIDTH (RQST_ADDR_BITWIDTH)
  ) u_lane_unpack (
    .i_vld       (w_vld),
    .i_rdata     (rdata_i),
    .o_rqst_addr (rqst_addr_o),
    .o_lane_vld  (lane_vld_o)
  );

  assign raddr_o     = w_raddr;
  assign rqst_vld_o  = w_vld;
  assign busy_o      = (r_state != IDLE);
  assign done_o      = (r_state == DONE);
  assign stall_cnt_o = r_stall;

endmodule

// File: tb/tb_msgpass_rqst_stream_seq.sv
module tb_msgpass_rqst_stream_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        loop_en;
  logic [3:0]  base;
  logic [4:0]  len;
  logic [0:0]  drc;
  logic [3:0]  raddr;
  logic [19:0] rdata;
  logic [14:0] addr;
  logic [4:0]  lvld;
  logic        vld;
  logic        busy;
  logic        done;
  logic [15:0] stall;

  int total = 0;
  int bad   = 0;

  logic [19:0] mem [16];

  always #5 clk = ~clk;

  // Buffer port A model: one-cycle synchronous read.
  always @(posedge clk) rdata <= mem[raddr];

  msgpass_rqst_stream_seq dut (
    .sys_clk     (clk),
    .rst         (rst),
    .start_i     (start),
    .abort_i     (abort),
    .loop_en_i   (loop_en),
    .base_addr_i (base),
    .len_i       (len),
    .is_drc_i    (drc),
    .raddr_o     (raddr),
    .rdata_i     (rdata),
    .rqst_addr_o (addr),
    .lane_vld_o  (lvld),
    .rqst_vld_o  (vld),
    .busy_o      (busy),
    .done_o      (done),
    .stall_cnt_o (stall)
  );

  // Entry e: lane j address = (e+j) mod 8; lanes 0..3 valid = bit j of e, lane 4 always valid.
  function automatic logic [14:0] exp_addr(input int e);
    logic [14:0] r;
    for (int j = 0; j < 5; j++) r[j*3 +: 3] = 3'((e + j) % 8);
    return r;
  endfunction

  function automatic logic [4:0] exp_vld(input int e);
    return {1'b1, 4'(e)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; abort = 0; loop_en = 0; base = 0; len = 0; drc = 0;
    tick; tick; #1;
    total++;
    if ({vld, busy, done, raddr, stall, addr, lvld} !== 42'd0) begin
      bad++;
      $display("FAIL reset_outputs: got vld=%b busy=%b done=%b raddr=%0d stall=%0d addr=%h lv=%b want all zero",
               vld, busy, done, raddr, stall, addr, lvld);
    end
    tick; rst = 1'b0; #1;
    total++;
    if ({vld, busy, done, raddr} !== 7'd0) begin
      bad++;
      $display("FAIL reset_release: got vld=%b busy=%b done=%b raddr=%0d want 0", vld, busy, done, raddr);
    end
  endtask

  task automatic test_basic;
    int e_raddr [3] = '{1, 2, 2};
    tick; start = 1; base = 0; len = 3; loop_en = 0; #1;
    total++;
    if ({busy, vld} !== 2'b00) begin
      bad++; $display("FAIL basic_idle: got busy=%b vld=%b want 0 0", busy, vld);
    end
    tick; start = 0; #1;
    total++;
    if ({busy, vld, raddr} !== {1'b1, 1'b0, 4'd0}) begin
      bad++; $display("FAIL basic_prime: got busy=%b vld=%b raddr=%0d want 1 0 0", busy, vld, raddr);
    end
    for (int k = 0; k < 3; k++) begin
      tick; #1;
      total++;
      if ({vld, addr, lvld} !== {1'b1, exp_addr(k), exp_vld(k)}) begin
        bad++; $display("FAIL basic_entry%0d: got vld=%b addr=%h lv=%b want 1 %h %b",
                        k, vld, addr, lvld, exp_addr(k), exp_vld(k));
      end
      total++;
      if (raddr !== 4'(e_raddr[k])) begin
        bad++; $display("FAIL basic_raddr%0d: got %0d want %0d", k, raddr, e_raddr[k]);
      end
    end
    tick; #1;
    total++;
    if ({done, vld, busy, addr, lvld} !== {3'b101, 20'd0}) begin
      bad++; $display("FAIL basic_done: got done=%b vld=%b busy=%b addr=%h lv=%b want 1 0 1 0 0",
                      done, vld, busy, addr, lvld);
    end
    tick; #1;
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++; $display("FAIL basic_idle_after: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_drc_stall;
    int e_ent [5]   = '{0, 0, 0, 1, 2};
    int e_raddr [5] = '{0, 0, 1, 2, 2};
    int e_stall [5] = '{0, 1, 2, 2, 2};
    logic [0:0] d_seq [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tick; start = 1; base = 0; len = 3; #1;
    tick; start = 0; #1;
    for (int k = 0; k < 5; k++) begin
      tick; drc = d_seq[k]; #1;
      total++;
      if ({vld, addr, lvld, raddr} !== {1'b1, exp_addr(e_ent[k]), exp_vld(e_ent[k]), 4'(e_raddr[k])}) begin
        bad++; $display("FAIL drc_cycle%0d: got vld=%b addr=%h lv=%b raddr=%0d want entry %0d raddr %0d",
                        k, vld, addr, lvld, raddr, e_ent[k], e_raddr[k]);
      end
      total++;
      if (stall !== 16'(e_stall[k])) begin
        bad++; $display("FAIL drc_stall%0d: got %0d want %0d", k, stall, e_stall[k]);
      end
    end
    tick; drc = 0; #1;
    total++;
    if ({done, vld, stall} !== {1'b1, 1'b0, 16'd2}) begin
      bad++; $display("FAIL drc_done: got done=%b vld=%b stall=%0d want 1 0 2", done, vld, stall);
    end
    tick; #1;
  endtask

  task automatic test_wrap;
    int e_ent [4]   = '{14, 15, 0, 1};
    int e_raddr [4] = '{15, 0, 1, 1};
    tick; start = 1; base = 14; len = 4; #1;
    tick; start = 0; #1;
    total++;
    if ({raddr, stall} !== {4'd14, 16'd0}) begin
      bad++; $display("FAIL wrap_prime: got raddr=%0d stall=%0d want 14 0", raddr, stall);
    end
    for (int k = 0; k < 4; k++) begin
      tick; #1;
      total++;
      if ({vld, addr, lvld, raddr} !== {1'b1, exp_addr(e_ent[k]), exp_vld(e_ent[k]), 4'(e_raddr[k])}) begin
        bad++; $display("FAIL wrap_cycle%0d: got vld=%b addr=%h lv=%b raddr=%0d want entry %0d raddr %0d",
                        k, vld, addr, lvld, raddr, e_ent[k], e_raddr[k]);
      end
    end
    tick; #1;
    total++;
    if ({done, vld} !== 2'b10) begin
      bad++; $display("FAIL wrap_done: got done=%b vld=%b want 1 0", done, vld);
    end
    tick; #1;
  endtask

  task automatic test_loop_abort;
    int e_ent [6]   = '{2, 3, 3, 2, 3, 2};
    int e_raddr [6] = '{3, 3, 2, 3, 2, 3};
    logic [0:0] d_seq [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tick; start = 1; base = 2; len = 2; loop_en = 1; #1;
    tick; start = 0; #1;
    for (int k = 0; k < 6; k++) begin
      tick; drc = d_seq[k]; abort = (k == 5); #1;
      total++;
      if ({vld, done, addr, lvld, raddr} !== {2'b10, exp_addr(e_ent[k]), exp_vld(e_ent[k]), 4'(e_raddr[k])}) begin
        bad++; $display("FAIL loop_cycle%0d: got vld=%b done=%b addr=%h lv=%b raddr=%0d want entry %0d raddr %0d",
                        k, vld, done, addr, lvld, raddr, e_ent[k], e_raddr[k]);
      end
    end
    tick; abort = 0; drc = 0; loop_en = 0; #1;
    total++;
    if ({vld, busy, done, stall} !== {3'b000, 16'd1}) begin
      bad++; $display("FAIL loop_abort: got vld=%b busy=%b done=%b stall=%0d want 0 0 0 1", vld, busy, done, stall);
    end
    tick; #1;
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++; $display("FAIL loop_no_done: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_len0_and_ignore;
    int e_ent [3]   = '{5, 6, 7};
    int e_raddr [3] = '{6, 7, 7};
    tick; start = 1; base = 9; len = 0; #1;
    tick; start = 0; #1;
    total++;
    if ({done, vld, busy} !== 3'b101) begin
      bad++; $display("FAIL len0_done: got done=%b vld=%b busy=%b want 1 0 1", done, vld, busy);
    end
    tick; #1;
    total++;
    if ({done, vld, busy} !== 3'b000) begin
      bad++; $display("FAIL len0_idle: got done=%b vld=%b busy=%b want 0 0 0", done, vld, busy);
    end
    start = 1; abort = 1; base = 5; len = 3;
    tick; start = 0; abort = 0; #1;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL abort_beats_start: got busy=%b want 0", busy);
    end
    start = 1; base = 5; len = 3;
    tick; start = 0; #1;
    total++;
    if ({busy, raddr} !== {1'b1, 4'd5}) begin
      bad++; $display("FAIL ignore_prime: got busy=%b raddr=%0d want 1 5", busy, raddr);
    end
    for (int k = 0; k < 3; k++) begin
      tick; start = (k == 0); base = 0; len = 1; #1;
      total++;
      if ({vld, addr, lvld, raddr} !== {1'b1, exp_addr(e_ent[k]), exp_vld(e_ent[k]), 4'(e_raddr[k])}) begin
        bad++; $display("FAIL ignore_cycle%0d: got vld=%b addr=%h lv=%b raddr=%0d want entry %0d raddr %0d",
                        k, vld, addr, lvld, raddr, e_ent[k], e_raddr[k]);
      end
    end
    tick; start = 0; #1;
    total++;
    if ({done, vld} !== 2'b10) begin
      bad++; $display("FAIL ignore_done: got done=%b vld=%b want 1 0", done, vld);
    end
    tick; #1;
  endtask

  task automatic test_rst_mid;
    tick; start = 1; base = 0; len = 3; #1;
    tick; start = 0; #1;
    tick; drc = 1; #1;
    tick; drc = 0; #1;
    total++;
    if ({vld, stall} !== {1'b1, 16'd1}) begin
      bad++; $display("FAIL rst_pre: got vld=%b stall=%0d want 1 1", vld, stall);
    end
    rst = 1; #1;
    total++;
    if ({vld, busy, done, raddr, stall, addr, lvld} !== 42'd0) begin
      bad++; $display("FAIL rst_async: got vld=%b busy=%b done=%b raddr=%0d stall=%0d addr=%h lv=%b want all zero",
                      vld, busy, done, raddr, stall, addr, lvld);
    end
    tick; rst = 0; start = 1; base = 4; len = 1; #1;
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++; $display("FAIL rst_idle: got busy=%b done=%b want 0 0", busy, done);
    end
    tick; start = 0; #1;
    total++;
    if ({busy, vld, raddr} !== {2'b10, 4'd4}) begin
      bad++; $display("FAIL rst_restart_prime: got busy=%b vld=%b raddr=%0d want 1 0 4", busy, vld, raddr);
    end
    tick; #1;
    total++;
    if ({vld, addr, lvld, raddr, stall} !== {1'b1, exp_addr(4), exp_vld(4), 4'd4, 16'd0}) begin
      bad++; $display("FAIL rst_restart_entry: got vld=%b addr=%h lv=%b raddr=%0d stall=%0d want entry 4 raddr 4 stall 0",
                      vld, addr, lvld, raddr, stall);
    end
    tick; #1;
    total++;
    if ({done, vld} !== 2'b10) begin
      bad++; $display("FAIL rst_restart_done: got done=%b vld=%b want 1 0", done, vld);
    end
    tick; #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      logic [3:0] ib;
      ib = 4'(i);
      for (int j = 0; j < 5; j++) begin
        mem[i][j*4 +: 3] = 3'((i + j) % 8);
        mem[i][j*4 + 3]  = (j == 4) ? 1'b1 : ib[j];
      end
    end
    test_reset;
    test_basic;
    test_drc_stall;
    test_wrap;
    test_loop_abort;
    test_len0_and_ignore;
    test_rst_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
